echo_client: RTL and testbench
==============================

Name: echo_client

Overview:
- Initiator for the 0x1234 Ethernet echo service.
- Builds an echo request in the TX packet buffer and rings the mac_tx_ifc doorbell.
- Waits for the reflected frame from mac_rx_ifc, checks it byte-for-byte, and keeps pass/fail/timeout statistics.
- Sits in the RMII refclk domain, between mac_tx_ifc/mac_rx_ifc and board I/O (buttons, LEDs).

Parameters:
- MY_ADDR, 48'hb8_27_eb_a4_30_74: own MAC address, placed in the source field.
- PEER_ADDR, 48'hb8_27_eb_a4_30_73: responder MAC address, placed in the destination field.
- ECHO_ETYPE, 16'h1234: ethertype of requests and of accepted replies.
- PAYLOAD_LEN, 46: payload bytes, legal range 1..1504.
- TIMEOUT_CYCLES, 500000: reply wait limit in clk cycles (10 ms at 50 MHz).

Ports:
- clk  in  1  50 MHz refclk domain clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  level; sampled in ST_IDLE; launches one request.
- continuous  in  1  when high, a new request launches automatically after each result.
- tx_pktbuf  out  [1517:0][7:0]  request frame to mac_tx_ifc.
- tx_pktbuf_maxaddr  out  11  index of last valid byte.
- tx_doorbell  out  1  one-cycle send pulse.
- tx_available  in  1  mac_tx_ifc can accept a frame.
- rx_pktbuf  in  [1517:0][7:0]  received frame from mac_rx_ifc.
- rx_pktbuf_maxaddr  in  11  last valid rx byte index.
- rx_doorbell  in  1  high while rx_pktbuf holds a new frame.
- busy  out  1  high in every state except ST_IDLE.
- last_pass  out  1  result of the most recent completed transaction.
- seq  out  8  sequence number of the current/next request.
- pass_count, fail_count, timeout_count  out  16 each  saturating statistics.

Behaviour:
- Reset (rstn low, asynchronous): state=ST_IDLE. Every output is 0, including tx_pktbuf, counters, seq and last_pass.
- Frame layout:
  - tx_pktbuf[5:0] = PEER_ADDR; tx_pktbuf[11:6] = MY_ADDR; tx_pktbuf[13:12] = ECHO_ETYPE (packed slices).
  - tx_pktbuf[14+i] = seq + i mod 256, for i = 0..PAYLOAD_LEN-1.
  - Remaining bytes = 0.
  - tx_pktbuf_maxaddr = 13+PAYLOAD_LEN (59 at default).
- States:
  - ST_IDLE: go to ST_LOAD when start or continuous is high.
  - ST_LOAD: write the frame for the current seq; go to ST_PUSH next cycle.
  - ST_PUSH: hold until tx_available=1. On that cycle, register tx_doorbell=1 for exactly one cycle, clear the timer, go to ST_WAIT.
  - ST_WAIT:
    - Timer increments each cycle.
    - A rising edge of rx_doorbell with rx ethertype == ECHO_ETYPE moves to ST_CHECK.
    - A rising edge with any other ethertype is ignored; the timer keeps running.
    - When timer == TIMEOUT_CYCLES-1 with no accepted edge: timeout_count++, last_pass=0, go to ST_DONE.
    - An accepted edge on that same final cycle wins over the timeout.
  - ST_CHECK: pass if all of the following hold, else fail:
    - rx[5:0] == MY_ADDR;
    - rx[11:6] == PEER_ADDR;
    - rx_pktbuf_maxaddr == tx_pktbuf_maxaddr;
    - every payload byte equals tx_pktbuf.

    Pass: pass_count++, last_pass=1. Fail: fail_count++, last_pass=0. Then go to ST_DONE.
  - ST_DONE:
    - seq increments (wraps 255->0).
    - Wait until rx_doorbell=0, so one frame is never consumed twice.
    - Then go to ST_IDLE.
- Doorbell edge detection: compares rx_doorbell with its 1-cycle-delayed copy. The delayed copy is reset to 0.
- Latency: start high at cycle N in ST_IDLE with tx_available held high gives tx_doorbell high in cycle N+3 only.
- Simultaneous events and boundaries:
  - start while busy: ignored.
  - continuous dropped mid-transaction: the current transaction completes, then the block idles.
  - A comparison may only read rx_pktbuf within 2 cycles of the accepted edge (the buffer is valid for at least 48 cycles).
  - Counters saturate at 16'hFFFF.
  - tx_pktbuf is held stable from ST_LOAD until the next ST_LOAD.
- rstn low mid-transaction: immediate return to ST_IDLE with all outputs 0. A request already handed to mac_tx_ifc is not recalled.

Test Plan:
1. Reset, then start pulse with tx_available=1 -> tx_doorbell high for exactly one cycle at N+3; tx_pktbuf[13:12]=16'h1234; tx_pktbuf[14]=8'h00, tx_pktbuf[59]=8'h2D; maxaddr=59.
2. Bench model reflects the frame (MACs swapped, same payload) 200 cycles after the doorbell, rx_doorbell held high for 48 cycles -> pass_count=1, last_pass=1, seq=1, single count despite the long doorbell.
3. Reflected frame with payload byte 30 corrupted to 8'hFF -> fail_count=1, last_pass=0. Repeat with maxaddr=60 -> fail_count=2.
4. No reply -> timeout_count=1 exactly TIMEOUT_CYCLES cycles after the doorbell (set TIMEOUT_CYCLES=1000 in the bench). A frame with ethertype 16'h0800 arriving mid-wait is ignored.
5. continuous=1, tx_available toggling every 7 cycles, 300 echoed transactions -> pass_count=300, seq wraps to 44, no doorbell while tx_available=0.
6. rstn low during ST_WAIT and during ST_PUSH -> outputs immediately 0, state ST_IDLE; next start behaves as in test 1.

Source files
------------

// File: rtl/echo_client.sv
// Initiator for the 0x1234 Ethernet echo service: builds a request frame, rings the TX doorbell,
// then validates the reflected frame and keeps saturating pass/fail/timeout statistics.
module echo_client #(
   parameter logic [47:0] MY_ADDR        = 48'hb8_27_eb_a4_30_74,
   parameter logic [47:0] PEER_ADDR      = 48'hb8_27_eb_a4_30_73,
   parameter logic [15:0] ECHO_ETYPE     = 16'h1234,
   parameter int unsigned PAYLOAD_LEN    = 46,
   parameter int unsigned TIMEOUT_CYCLES = 500000
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic                continuous,
   output logic [1517:0][7:0]  tx_pktbuf,
   output logic [10:0]         tx_pktbuf_maxaddr,
   output logic                tx_doorbell,
   input  logic                tx_available,
   input  logic [1517:0][7:0]  rx_pktbuf,
   input  logic [10:0]         rx_pktbuf_maxaddr,
   input  logic                rx_doorbell,
   output logic                busy,
   output logic                last_pass,
   output logic [7:0]          seq,
   output logic [15:0]         pass_count,
   output logic [15:0]         fail_count,
   output logic [15:0]         timeout_count
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_PUSH  = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_CHECK = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   localparam logic [10:0] MAXADDR = 11'(13 + PAYLOAD_LEN);

   logic [2:0]          state_q, state_d;
   logic [1517:0][7:0]  pktbuf_q, pktbuf_d;
   logic [10:0]         maxaddr_q, maxaddr_d;
   logic                doorbell_q, doorbell_d;
   logic [31:0]         timer_q, timer_d;
   logic [7:0]          seq_q, seq_d;
   logic [15:0]         pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d;
   logic                last_q, last_d;
   logic                rx_db_q;

   logic [1517:0][7:0]  frame;
   logic                reply_ok;
   logic                rx_accept;

   always_comb begin
      frame        = '0;
      frame[5:0]   = PEER_ADDR;
      frame[11:6]  = MY_ADDR;
      frame[13:12] = ECHO_ETYPE;
      for (int unsigned i = 0; i < PAYLOAD_LEN; i++) begin
         frame[14+i] = seq_q + 8'(i);
      end
   end

   always_comb begin
      reply_ok = (rx_pktbuf[5:0] == MY_ADDR) && (rx_pktbuf[11:6] == PEER_ADDR) &&
                 (rx_pktbuf_maxaddr == maxaddr_q);
      for (int unsigned i = 0; i < PAYLOAD_LEN; i++) begin
         if (rx_pktbuf[14+i] != pktbuf_q[14+i]) reply_ok = 1'b0;
      end
   end

   // Only a fresh doorbell edge carrying our ethertype counts as a reply.
   assign rx_accept = rx_doorbell && !rx_db_q && (rx_pktbuf[13:12] == ECHO_ETYPE);

   always_comb begin
      state_d    = state_q;
      pktbuf_d   = pktbuf_q;
      maxaddr_d  = maxaddr_q;
      doorbell_d = 1'b0;
      timer_d    = timer_q;
      seq_d      = seq_q;
      pass_d     = pass_q;
      fail_d     = fail_q;
      tmo_d      = tmo_q;
      last_d     = last_q;
      case (state_q)
         ST_IDLE: if (start || continuous) state_d = ST_LOAD;
         ST_LOAD: begin
            pktbuf_d  = frame;
            maxaddr_d = MAXADDR;
            state_d   = ST_PUSH;
         end
         ST_PUSH: begin
            if (tx_available) begin
               doorbell_d = 1'b1;
               timer_d    = '0;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            timer_d = timer_q + 32'd1;
            if (rx_accept) begin
               state_d = ST_CHECK;
            end else if (timer_q == TIMEOUT_CYCLES - 1) begin
               tmo_d   = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
               last_d  = 1'b0;
               state_d = ST_DONE;
            end
         end
         ST_CHECK: begin
            if (reply_ok) begin
               pass_d = (pass_q == 16'hFFFF) ? pass_q : pass_q + 16'd1;
               last_d = 1'b1;
            end else begin
               fail_d = (fail_q == 16'hFFFF) ? fail_q : fail_q + 16'd1;
               last_d = 1'b0;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            // Hold until the rx buffer is released so one frame is never consumed twice.
            if (!rx_doorbell) begin
               seq_d   = seq_q + 8'd1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         pktbuf_q   <= '0;
         maxaddr_q  <= '0;
         doorbell_q <= 1'b0;
         timer_q    <= '0;
         seq_q      <= '0;
         pass_q     <= '0;
         fail_q     <= '0;
         tmo_q      <= '0;
         last_q     <= 1'b0;
         rx_db_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pktbuf_q   <= pktbuf_d;
         maxaddr_q  <= maxaddr_d;
         doorbell_q <= doorbell_d;
         timer_q    <= timer_d;
         seq_q      <= seq_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
         tmo_q      <= tmo_d;
         last_q     <= last_d;
         rx_db_q    <= rx_doorbell;
      end
   end

   assign tx_pktbuf         = pktbuf_q;
   assign tx_pktbuf_maxaddr = maxaddr_q;
   assign tx_doorbell       = doorbell_q;
   assign busy              = (state_q != ST_IDLE);
   assign last_pass         = last_q;
   assign seq               = seq_q;
   assign pass_count        = pass_q;
   assign fail_count        = fail_q;
   assign timeout_count     = tmo_q;

endmodule

// File: tb/tb_echo_client.sv
// Directed bench for echo_client: acts as the responder and checks frames, latency and statistics.
module tb_echo_client;

   localparam logic [47:0] MY   = 48'hb8_27_eb_a4_30_74;
   localparam logic [47:0] PEER = 48'hb8_27_eb_a4_30_73;

   logic                clk = 1'b0;
   logic                rstn = 1'b0;
   logic                start = 1'b0;
   logic                continuous = 1'b0;
   logic [1517:0][7:0]  tx_pktbuf;
   logic [10:0]         tx_pktbuf_maxaddr;
   logic                tx_doorbell;
   logic                tx_available = 1'b1;
   logic [1517:0][7:0]  rx_pktbuf = '0;
   logic [10:0]         rx_pktbuf_maxaddr = '0;
   logic                rx_doorbell = 1'b0;
   logic                busy, last_pass;
   logic [7:0]          seq;
   logic [15:0]         pass_count, fail_count, timeout_count;

   int n_assert = 0;
   int n_fail   = 0;

   echo_client #(.TIMEOUT_CYCLES(1000)) dut (
      .clk               (clk),
      .rstn              (rstn),
      .start             (start),
      .continuous        (continuous),
      .tx_pktbuf         (tx_pktbuf),
      .tx_pktbuf_maxaddr (tx_pktbuf_maxaddr),
      .tx_doorbell       (tx_doorbell),
      .tx_available      (tx_available),
      .rx_pktbuf         (rx_pktbuf),
      .rx_pktbuf_maxaddr (rx_pktbuf_maxaddr),
      .rx_doorbell       (rx_doorbell),
      .busy              (busy),
      .last_pass         (last_pass),
      .seq               (seq),
      .pass_count        (pass_count),
      .fail_count        (fail_count),
      .timeout_count     (timeout_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_txdb"}, 64'(tx_doorbell), 64'd0);
      chk({tag, "_pktbuf"}, 64'(tx_pktbuf == '0), 64'd1);
      chk({tag, "_maxaddr"}, 64'(tx_pktbuf_maxaddr), 64'd0);
      chk({tag, "_seq"}, 64'(seq), 64'd0);
      chk({tag, "_last"}, 64'(last_pass), 64'd0);
      chk({tag, "_cnts"}, 64'({pass_count, fail_count, timeout_count}), 64'd0);
   endtask

   // Responder model: reflected frame built from the bench's own expectation of the request.
   task automatic set_rx(input logic [7:0] s, input int corrupt, input logic [10:0] maxa,
                         input logic [15:0] et);
      rx_pktbuf = '0;
      rx_pktbuf[5:0]   = MY;
      rx_pktbuf[11:6]  = PEER;
      rx_pktbuf[13:12] = et;
      for (int i = 0; i < 46; i++) rx_pktbuf[14+i] = s + 8'(i);
      if (corrupt >= 0) rx_pktbuf[14+corrupt] = 8'hFF;
      rx_pktbuf_maxaddr = maxa;
   endtask

   task automatic launch();
      int k;
      start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      while (!tx_doorbell && k < 50) begin
         step();
         k++;
      end
      chk("doorbell_seen", 64'(tx_doorbell), 64'd1);
   endtask

   task automatic reply(input logic [7:0] s, input int corrupt, input logic [10:0] maxa);
      repeat (20) step();
      set_rx(s, corrupt, maxa, 16'h1234);
      rx_doorbell = 1'b1;
      repeat (48) step();
      rx_doorbell = 1'b0;
      repeat (3) step();
   endtask

   initial begin
      int cyc, db_cnt, replies, dly, hold;
      logic [7:0] mseq;

      #12;
      chk_zero("reset");
      rstn = 1'b1;
      step();

      // Test 1: latency and frame contents
      start = 1'b1;
      step();
      start = 1'b0;
      chk("lat_n1", 64'(tx_doorbell), 64'd0);
      step();
      chk("lat_n2", 64'(tx_doorbell), 64'd0);
      step();
      chk("lat_n3", 64'(tx_doorbell), 64'd1);
      chk("etype", 64'(tx_pktbuf[13:12]), 64'h1234);
      chk("dst", 64'(tx_pktbuf[5:0]), 64'(PEER));
      chk("src", 64'(tx_pktbuf[11:6]), 64'(MY));
      chk("pay0", 64'(tx_pktbuf[14]), 64'h00);
      chk("pay45", 64'(tx_pktbuf[59]), 64'h2D);
      chk("pad60", 64'(tx_pktbuf[60]), 64'h00);
      chk("maxaddr", 64'(tx_pktbuf_maxaddr), 64'd59);
      step();
      chk("lat_n4", 64'(tx_doorbell), 64'd0);

      // Test 2: good echo, long doorbell counted once
      repeat (199) step();
      set_rx(8'd0, -1, 11'd59, 16'h1234);
      rx_doorbell = 1'b1;
      repeat (48) step();
      rx_doorbell = 1'b0;
      repeat (3) step();
      chk("t2_pass", 64'(pass_count), 64'd1);
      chk("t2_last", 64'(last_pass), 64'd1);
      chk("t2_seq", 64'(seq), 64'd1);
      chk("t2_idle", 64'(busy), 64'd0);

      // Test 3: corrupted payload, then wrong length
      launch();
      chk("t3_pay0", 64'(tx_pktbuf[14]), 64'h01);
      reply(8'd1, 30, 11'd59);
      chk("t3_fail1", 64'(fail_count), 64'd1);
      chk("t3_last", 64'(last_pass), 64'd0);
      launch();
      reply(8'd2, -1, 11'd60);
      chk("t3_fail2", 64'(fail_count), 64'd2);
      chk("t3_pass", 64'(pass_count), 64'd1);
      chk("t3_seq", 64'(seq), 64'd3);

      // Test 4: timeout with a foreign-ethertype frame ignored mid-wait
      launch();
      for (int k = 1; k <= 1000; k++) begin
         step();
         if (k == 300) begin
            set_rx(8'd3, -1, 11'd59, 16'h0800);
            rx_doorbell = 1'b1;
         end
         if (k == 348) rx_doorbell = 1'b0;
         if (k == 999) begin
            chk("t4_before", 64'(timeout_count), 64'd0);
            chk("t4_busy", 64'(busy), 64'd1);
         end
      end
      chk("t4_tmo", 64'(timeout_count), 64'd1);
      chk("t4_last", 64'(last_pass), 64'd0);
      chk("t4_pass", 64'(pass_count), 64'd1);
      repeat (3) step();
      chk("t4_seq", 64'(seq), 64'd4);

      // Test 5: continuous mode with tx_available toggling every 7 cycles
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      step();
      cyc = 0; db_cnt = 0; replies = 0; dly = -1; hold = 0; mseq = 8'd0;
      tx_available = 1'b1;
      continuous = 1'b1;
      while (cyc < 20000 && !(replies == 300 && !busy && !rx_doorbell)) begin
         step();
         cyc++;
         if (tx_doorbell) begin
            chk("t5_db_avail", 64'(tx_available), 64'd1);
            db_cnt++;
            dly = 5;
         end
         if (hold > 0) begin
            hold--;
            if (hold == 0) rx_doorbell = 1'b0;
         end
         if (dly > 0) begin
            dly--;
            if (dly == 0) begin
               set_rx(mseq, -1, 11'd59, 16'h1234);
               mseq++;
               rx_doorbell = 1'b1;
               hold = 3;
               replies++;
               if (replies == 300) continuous = 1'b0;
               dly = -1;
            end
         end
         tx_available = ((cyc / 7) % 2) == 0;
      end
      chk("t5_bound", 64'(cyc < 20000), 64'd1);
      chk("t5_pass", 64'(pass_count), 64'd300);
      chk("t5_fail", 64'(fail_count), 64'd0);
      chk("t5_tmo", 64'(timeout_count), 64'd0);
      chk("t5_seq", 64'(seq), 64'd44);
      chk("t5_dbcnt", 64'(db_cnt), 64'd300);

      // Test 6: reset in ST_WAIT and in ST_PUSH
      tx_available = 1'b1;
      launch();
      repeat (10) step();
      #2 rstn = 1'b0;
      #1 chk_zero("rst_wait");
      step();
      rstn = 1'b1;
      tx_available = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (2) step();
      chk("push_busy", 64'(busy), 64'd1);
      #2 rstn = 1'b0;
      #1 chk_zero("rst_push");
      step();
      rstn = 1'b1;
      tx_available = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("t6_n2", 64'(tx_doorbell), 64'd0);
      step();
      chk("t6_n3", 64'(tx_doorbell), 64'd1);
      chk("t6_etype", 64'(tx_pktbuf[13:12]), 64'h1234);
      chk("t6_pay0", 64'(tx_pktbuf[14]), 64'h00);
      chk("t6_maxaddr", 64'(tx_pktbuf_maxaddr), 64'd59);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
